// File: rtl/eth_status_counters_if.sv
// Read port of the Ethernet statistics block.
// The master issues counter-select requests. The slave returns one data beat per
// accepted request, exactly one cycle later.
interface eth_status_counters_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  rd_addr;
    logic        rd_clear;
    logic        rd_data_valid;
    logic [31:0] rd_data;

    modport master (
        output rd_valid, rd_addr, rd_clear,
        input  rd_ready, rd_data_valid, rd_data
    );

    modport slave (
        input  rd_valid, rd_addr, rd_clear,
        output rd_ready, rd_data_valid, rd_data
    );
endinterface

// File: rtl/eth_status_counters.sv
// Saturating statistics counters for the 10G MAC.
// - Nine status-pulse event counters.
// - RX/TX frame and byte counters, fed from passive AXIS handshake taps.
// - A sticky saturation bitmap.
// - A fixed one-cycle read port with optional read-and-clear.
module eth_status_counters #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [15:0]                 status_in,
    input  logic                        tx_tap_tvalid,
    input  logic                        tx_tap_tready,
    input  logic                        tx_tap_tlast,
    input  logic [7:0]                  tx_tap_tkeep,
    input  logic                        rx_tap_tvalid,
    input  logic                        rx_tap_tready,
    input  logic                        rx_tap_tlast,
    input  logic [7:0]                  rx_tap_tkeep,
    eth_status_counters_if.slave        rd_bus
);

    localparam int NUM_CNT  = 13;
    localparam int ADDR_SAT = 13;
    localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = '1;

    // Popcount of a tkeep byte-enable vector. Non-contiguous patterns count too.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic [COUNTER_WIDTH-1:0] cnt_reg  [NUM_CNT];
    logic [COUNTER_WIDTH-1:0] cnt_next [NUM_CNT];
    logic [3:0]               inc_val  [NUM_CNT];
    logic [NUM_CNT-1:0]       flag_reg;
    logic [NUM_CNT-1:0]       flag_next;
    logic                     rd_ready_reg;
    logic                     rd_data_valid_reg;
    logic [31:0]              rd_data_reg;
    logic [31:0]              rd_mux;
    logic                     rd_accept;
    logic                     clr_flags;
    logic                     rx_beat;
    logic                     tx_beat;
    logic                     unused_status_bits;

    assign unused_status_bits = ^status_in[15:9];

    assign rd_accept = rd_bus.rd_valid & rd_ready_reg;
    assign clr_flags = rd_accept & rd_bus.rd_clear & (rd_bus.rd_addr == 4'(ADDR_SAT));

    assign rx_beat = rx_tap_tvalid & rx_tap_tready;
    assign tx_beat = tx_tap_tvalid & tx_tap_tready;

    // Per-counter increment for this cycle, as a 4-bit quantity (0..8).
    genvar gi;
    for (gi = 0; gi < 9; gi++) begin : g_evt_inc
        assign inc_val[gi] = {3'b000, status_in[gi]};
    end
    assign inc_val[9]  = {3'b000, rx_beat & rx_tap_tlast};
    assign inc_val[10] = rx_beat ? popcount8(rx_tap_tkeep) : 4'd0;
    assign inc_val[11] = {3'b000, tx_beat & tx_tap_tlast};
    assign inc_val[12] = tx_beat ? popcount8(tx_tap_tkeep) : 4'd0;

    // Saturating add plus clear handling.
    // A cleared counter restarts at this cycle's increment, so no event is dropped.
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        logic [COUNTER_WIDTH:0]   sum;
        logic [COUNTER_WIDTH-1:0] sat_val;
        logic                     clr_this;
        logic                     sat_hit;

        assign sum      = {1'b0, cnt_reg[gi]} + (COUNTER_WIDTH+1)'(inc_val[gi]);
        assign sat_val  = sum[COUNTER_WIDTH] ? ALL_ONES : sum[COUNTER_WIDTH-1:0];
        assign clr_this = rd_accept & rd_bus.rd_clear & (rd_bus.rd_addr == 4'(gi));
        // An increment that lands on (or clamps at) all-ones marks the counter saturated.
        assign sat_hit  = (inc_val[gi] != 4'd0) & (sat_val == ALL_ONES) & ~clr_this;

        assign cnt_next[gi]  = clr_this ? COUNTER_WIDTH'(inc_val[gi]) : sat_val;
        assign flag_next[gi] = clr_this  ? 1'b0 :
                               clr_flags ? sat_hit :
                                           (flag_reg[gi] | sat_hit);
    end

    // Read-data select. The value is taken before this cycle's update lands.
    always_comb begin
        rd_mux = 32'd0;
        if (rd_bus.rd_addr < 4'(NUM_CNT)) begin
            rd_mux = 32'(cnt_reg[rd_bus.rd_addr]);
        end else if (rd_bus.rd_addr == 4'(ADDR_SAT)) begin
            rd_mux = 32'(flag_reg);
        end
    end

    // State update for the counters, the flags and the registered read response.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_reg[i] <= '0;
            end
            flag_reg          <= '0;
            rd_ready_reg      <= 1'b0;
            rd_data_valid_reg <= 1'b0;
            rd_data_reg       <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            flag_reg          <= flag_next;
            rd_ready_reg      <= 1'b1;
            rd_data_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_data_reg <= rd_mux;
            end
        end
    end

    assign rd_bus.rd_ready      = rd_ready_reg;
    assign rd_bus.rd_data_valid = rd_data_valid_reg;
    assign rd_bus.rd_data       = rd_data_reg;

endmodule

// File: tb/tb_eth_status_counters.sv
// Bench for eth_status_counters with COUNTER_WIDTH = 8.
// A behavioural counter model predicts every response and flag state.
// Directed steps are followed by a randomized phase.
module tb_eth_status_counters;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] status_in;
    logic        tx_v, tx_r, tx_l;
    logic [7:0]  tx_k;
    logic        rx_v, rx_r, rx_l;
    logic [7:0]  rx_k;

    always #5 clk = ~clk;

    eth_status_counters_if rd_if ();

    eth_status_counters #(.COUNTER_WIDTH(W)) dut (
        .clock         (clk),
        .resetn        (resetn),
        .status_in     (status_in),
        .tx_tap_tvalid (tx_v),
        .tx_tap_tready (tx_r),
        .tx_tap_tlast  (tx_l),
        .tx_tap_tkeep  (tx_k),
        .rx_tap_tvalid (rx_v),
        .rx_tap_tready (rx_r),
        .rx_tap_tlast  (rx_l),
        .rx_tap_tkeep  (rx_k),
        .rd_bus        (rd_if.slave)
    );

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          model_cnt [13];
    bit          model_flag [13];
    bit          model_ready;
    logic [31:0] last_data;
    logic [31:0] d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        assert (got === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] r;
        r = 32'd0;
        if (a < 13) r = 32'(model_cnt[a]);
        else if (a == 13) for (int i = 0; i < 13; i++) r[i] = model_flag[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 13; i++) begin
            model_cnt[i]  = 0;
            model_flag[i] = 0;
        end
        model_ready = 0;
        last_data   = 32'd0;
    endtask

    // Advance one clock with the currently driven inputs.
    // The model predicts the state, then the DUT response is checked.
    task automatic step(input string tag);
        int          inc [13];
        bit          acc, clr, hit;
        int          a, nv;
        logic [31:0] exp_data;
        exp_data = 32'd0;
        for (int i = 0; i < 9; i++) inc[i] = int'(status_in[i]);
        inc[9]  = (rx_v && rx_r && rx_l) ? 1 : 0;
        inc[10] = (rx_v && rx_r) ? $countones(rx_k) : 0;
        inc[11] = (tx_v && tx_r && tx_l) ? 1 : 0;
        inc[12] = (tx_v && tx_r) ? $countones(tx_k) : 0;
        check({tag, "_ready"}, {31'd0, rd_if.rd_ready}, {31'd0, model_ready});
        acc = rd_if.rd_valid && model_ready;
        clr = acc && rd_if.rd_clear;
        a   = int'(rd_if.rd_addr);
        if (acc) exp_data = model_read(a);
        for (int i = 0; i < 13; i++) begin
            if (clr && a == i) begin
                model_cnt[i]  = inc[i];
                model_flag[i] = 0;
            end else begin
                nv  = model_cnt[i] + inc[i];
                if (nv > MAXV) nv = MAXV;
                hit = (inc[i] > 0) && (nv == MAXV);
                model_cnt[i]  = nv;
                model_flag[i] = (clr && a == 13) ? hit : (model_flag[i] | hit);
            end
        end
        @(posedge clk);
        #1;
        model_ready = 1;
        check({tag, "_dvalid"}, {31'd0, rd_if.rd_data_valid}, {31'd0, acc});
        if (acc) last_data = exp_data;
        check({tag, "_data"}, rd_if.rd_data, last_data);
    endtask

    task automatic do_read(input int a, input bit clr, output logic [31:0] data);
        rd_if.rd_valid = 1'b1;
        rd_if.rd_addr  = 4'(a);
        rd_if.rd_clear = clr;
        step($sformatf("rd%0d", a));
        data = rd_if.rd_data;
        rd_if.rd_valid = 1'b0;
        rd_if.rd_clear = 1'b0;
        $display("read addr=%0d clear=%0d data=%0d", a, clr, data);
    endtask

    task automatic idle_taps();
        tx_v = 0; tx_r = 0; tx_l = 0; tx_k = 8'h00;
        rx_v = 0; rx_r = 0; rx_l = 0; rx_k = 8'h00;
    endtask

    task automatic tx_beat(input bit last, input logic [7:0] keep);
        tx_v = 1; tx_r = 1; tx_l = last; tx_k = keep;
        step("txbeat");
        idle_taps();
    endtask

    initial begin
        resetn = 1'b0;
        status_in = 16'h0000;
        idle_taps();
        rd_if.rd_valid = 1'b0;
        rd_if.rd_addr  = 4'd0;
        rd_if.rd_clear = 1'b0;
        model_reset();

        // Reset defaults.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, rd_if.rd_ready}, 32'd0);
        check("rst_dvalid", {31'd0, rd_if.rd_data_valid}, 32'd0);
        check("rst_data", rd_if.rd_data, 32'd0);
        resetn = 1'b1;
        rd_if.rd_valid = 1'b1;
        step("pre_ready");
        rd_if.rd_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            do_read(a, 0, d);
            check("reset_read", d, 32'd0);
        end

        // Status events, with ignored upper bits also active.
        status_in = 16'hFE20;
        repeat (3) step("evt");
        status_in = 16'hF000;
        step("evt_hi");
        status_in = 16'h0000;

        // RX frame FF, stall, FF, 0F.
        rx_v = 1; rx_r = 1; rx_l = 0; rx_k = 8'hFF; step("rx0");
        rx_r = 0; rx_l = 1; rx_k = 8'hAA;           step("rx_stall");
        rx_r = 1; rx_l = 0; rx_k = 8'hFF;           step("rx1");
        rx_l = 1; rx_k = 8'h0F;                     step("rx2");
        idle_taps();
        do_read(5, 0, d);  check("evt5", d, 32'd3);
        do_read(9, 0, d);  check("rx_frames", d, 32'd1);
        do_read(10, 0, d); check("rx_bytes", d, 32'd20);
        for (int a = 0; a < 13; a++) begin
            if (a != 5 && a != 9 && a != 10) begin
                do_read(a, 0, d);
                check("untouched", d, 32'd0);
            end
        end

        // Read-clear colliding with a TX tlast beat.
        repeat (7) tx_beat(1, 8'h01);
        tx_v = 1; tx_r = 1; tx_l = 1; tx_k = 8'h01;
        do_read(11, 1, d); check("collide_resp", d, 32'd7);
        idle_taps();
        do_read(11, 0, d); check("collide_after", d, 32'd1);

        // Saturation of TX bytes at 255.
        do_read(12, 1, d); check("txb_pre", d, 32'd8);
        repeat (31) tx_beat(0, 8'hFF);
        tx_beat(0, 8'h03);
        do_read(12, 0, d); check("txb_250", d, 32'd250);
        tx_beat(0, 8'hFF);
        do_read(12, 0, d); check("txb_sat", d, 32'd255);
        do_read(13, 0, d); check("sat_bit12", (d >> 12) & 32'd1, 32'd1);
        tx_beat(0, 8'hFF);
        do_read(12, 0, d); check("txb_hold", d, 32'd255);
        do_read(12, 1, d); check("txb_clr_resp", d, 32'd255);
        do_read(12, 0, d); check("txb_cleared", d, 32'd0);
        do_read(13, 0, d); check("sat_bit12_clr", (d >> 12) & 32'd1, 32'd0);

        // Back-to-back reads of addr 0, 1, 2 (values 1, 2, 3).
        status_in = 16'h0007; step("b2b_setup");
        status_in = 16'h0006; step("b2b_setup");
        status_in = 16'h0004; step("b2b_setup");
        status_in = 16'h0000;
        rd_if.rd_valid = 1'b1;
        for (int a = 0; a < 3; a++) begin
            rd_if.rd_addr = 4'(a);
            step("b2b");
            check("b2b_data", rd_if.rd_data, 32'(a + 1));
            $display("b2b addr=%0d data=%0d", a, rd_if.rd_data);
        end
        rd_if.rd_valid = 1'b0;

        // Randomized traffic and reads, checked against the model.
        for (int n = 0; n < 600; n++) begin
            status_in = 16'($urandom) & 16'($urandom);
            tx_v = 1'($urandom); tx_r = 1'($urandom); tx_l = 1'($urandom); tx_k = 8'($urandom);
            rx_v = 1'($urandom); rx_r = 1'($urandom); rx_l = 1'($urandom); rx_k = 8'($urandom);
            rd_if.rd_valid = 1'($urandom);
            rd_if.rd_addr  = 4'($urandom);
            rd_if.rd_clear = ($urandom_range(0, 3) == 0);
            step("rand");
            if (rd_if.rd_data_valid)
                $display("rand cycle=%0d data=%0d", n, rd_if.rd_data);
        end
        status_in = 16'h0000;
        idle_taps();
        rd_if.rd_valid = 1'b0;
        rd_if.rd_clear = 1'b0;

        // Reset mid-operation with a read in flight.
        status_in = 16'h01FF;
        step("pre_rst");
        status_in = 16'h0000;
        rd_if.rd_valid = 1'b1;
        rd_if.rd_addr  = 4'd0;
        #2 resetn = 1'b0;
        #1;
        check("midrst_ready", {31'd0, rd_if.rd_ready}, 32'd0);
        check("midrst_dvalid", {31'd0, rd_if.rd_data_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_noresp", {31'd0, rd_if.rd_data_valid}, 32'd0);
        check("midrst_data", rd_if.rd_data, 32'd0);
        resetn = 1'b1;
        rd_if.rd_valid = 1'b0;
        model_reset();
        step("post_rst");
        for (int a = 0; a < 16; a++) begin
            do_read(a, 0, d);
            check("post_rst_read", d, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
